// File: rtl/pmu_apb_pkg.sv
// Shared types and helpers for the APB front-end of PMU_raw.
// Holds the bridge FSM encoding and the byte-strobe merge.
package pmu_apb_pkg;

   localparam int PMU_REG_W  = 32;
   localparam int PMU_STRB_W = PMU_REG_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WR_COMMIT,
      RD_CAPTURE,
      RESP
   } apb_state_e;

   function automatic logic [PMU_REG_W-1:0] merge_strb(
      input logic [PMU_REG_W-1:0]  cur,
      input logic [PMU_REG_W-1:0]  wdata,
      input logic [PMU_STRB_W-1:0] strb
   );
      logic [PMU_REG_W-1:0] res;
      res = cur;
      for (int b = 0; b < PMU_STRB_W; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pmu_apb_bridge.sv
// APB3/APB4 responder driving the PMU_raw flat register array.
// Writes commit the whole array in one cycle; reads are registered.
module pmu_apb_bridge
   import pmu_apb_pkg::*;
#(
   parameter int REG_WIDTH  = 32,
   parameter int N_REGS     = 47,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [REG_WIDTH-1:0]  pwdata_i,
   input  logic [REG_WIDTH/8-1:0] pstrb_i,
   output logic [REG_WIDTH-1:0]  prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   output logic [REG_WIDTH-1:0]  regs_o [0:N_REGS-1],
   output logic                  wrapper_we_o,
   input  logic [REG_WIDTH-1:0]  regs_i [0:N_REGS-1]
);

   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam int STRB_W = REG_WIDTH / 8;

   apb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [REG_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]    strb_q, strb_d;
   logic                 write_q, write_d;
   logic                 err_q, err_d;
   logic [REG_WIDTH-1:0] prdata_q, prdata_d;
   logic                 pready_q, pready_d;
   logic                 pslverr_q, pslverr_d;
   logic                 we_q, we_d;

   logic [IDX_W-1:0]     setup_idx;
   logic                 setup_err;
   logic [REG_WIDTH-1:0] rd_word;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = ^paddr_i[1:0];

   assign setup_idx = paddr_i[ADDR_WIDTH-1:2];
   assign setup_err = 32'(setup_idx) >= 32'(N_REGS);

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            rd_word = regs_i[k];
         end
      end
   end

   // Untouched registers are fed back so a whole-array load is harmless.
   always_comb begin
      for (int k = 0; k < N_REGS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            regs_o[k] = merge_strb(regs_i[k], wdata_q, strb_q);
         end else begin
            regs_o[k] = regs_i[k];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      write_d   = write_q;
      err_d     = err_q;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      we_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               idx_d   = setup_idx;
               wdata_d = pwdata_i;
               strb_d  = pstrb_i;
               write_d = pwrite_i;
               err_d   = setup_err;
               we_d    = pwrite_i && !setup_err;
               state_d = pwrite_i ? WR_COMMIT : RD_CAPTURE;
            end
         end
         WR_COMMIT, RD_CAPTURE: begin
            prdata_d  = (write_q || err_q) ? '0 : rd_word;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            state_d   = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         write_q   <= write_d;
         err_q     <= err_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         we_q      <= we_d;
      end
   end

   assign prdata_o     = prdata_q;
   assign pready_o     = pready_q;
   assign pslverr_o    = pslverr_q;
   assign wrapper_we_o = we_q;

endmodule

// File: tb/tb_pmu_apb_bridge.sv
// Directed and random APB traffic against a word-array model of PMU_raw.
// Checks handshake timing, error responses, byte merges and resets.
module tb_pmu_apb_bridge;
   import pmu_apb_pkg::*;

   localparam int N = 47;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        psel_i, penable_i, pwrite_i;
   logic [7:0]  paddr_i;
   logic [31:0] pwdata_i;
   logic [3:0]  pstrb_i;
   logic [31:0] prdata_o;
   logic        pready_o, pslverr_o, wrapper_we_o;
   logic [31:0] regs_o [0:N-1];
   logic [31:0] pmu [0:N-1];
   logic [31:0] model [0:N-1];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pmu_apb_bridge #(
      .REG_WIDTH(32),
      .N_REGS(N),
      .ADDR_WIDTH(8)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn_i),
      .psel_i(psel_i),
      .penable_i(penable_i),
      .pwrite_i(pwrite_i),
      .paddr_i(paddr_i),
      .pwdata_i(pwdata_i),
      .pstrb_i(pstrb_i),
      .prdata_o(prdata_o),
      .pready_o(pready_o),
      .pslverr_o(pslverr_o),
      .regs_o(regs_o),
      .wrapper_we_o(wrapper_we_o),
      .regs_i(pmu)
   );

   // Stand-in for PMU_raw: loads the whole array on wrapper_we.
   always @(posedge clk) begin
      if (wrapper_we_o) pmu <= regs_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_mem(input string tag);
      logic [31:0] bad;
      bad = 32'hFFFF_FFFF;
      for (int i = N - 1; i >= 0; i--) begin
         if (pmu[i] !== model[i]) bad = i;
      end
      chk(tag, bad, 32'hFFFF_FFFF);
   endtask

   task automatic xfer(input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input bit drop, output logic [31:0] rd);
      int idx;
      bit err;
      logic [31:0] mask, exp_rd;
      idx = int'(addr >> 2);
      err = idx >= N;
      exp_rd = (wr || err) ? 32'h0 : model[idx];
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
      paddr_i = addr; pwdata_i = wd; pstrb_i = st;
      @(negedge clk);
      penable_i = 1'b1;
      if (drop) psel_i = 1'b0;
      chk("t1_pready", 32'(pready_o), 32'(0));
      chk("t1_we", 32'(wrapper_we_o), 32'(wr && !err));
      if (wr && !err) begin
         mask = 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (st[b]) mask = mask | (32'hFF << (8 * b));
         end
         model[idx] = (model[idx] & ~mask) | (wd & mask);
      end
      @(negedge clk);
      chk("t2_pready", 32'(pready_o), 32'(1));
      chk("t2_pslverr", 32'(pslverr_o), 32'(err));
      chk("t2_prdata", prdata_o, exp_rd);
      chk("t2_we", 32'(wrapper_we_o), 32'(0));
      rd = prdata_o;
      @(negedge clk);
      psel_i = 1'b0; penable_i = 1'b0;
      chk("t3_pready", 32'(pready_o), 32'(0));
      chk_mem("pmu_array");
   endtask

   initial begin
      logic [31:0] rd;
      bit wr, drop;
      logic [7:0] addr;
      for (int i = 0; i < N; i++) begin
         pmu[i] = 32'h0;
         model[i] = 32'h0;
      end
      rstn_i = 1'b0;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      paddr_i = 8'h0; pwdata_i = 32'h0; pstrb_i = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_pready", 32'(pready_o), 32'(0));
      chk("rst_pslverr", 32'(pslverr_o), 32'(0));
      chk("rst_prdata", prdata_o, 32'h0);
      chk("rst_we", 32'(wrapper_we_o), 32'(0));
      rstn_i = 1'b1;
      @(negedge clk);

      xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, rd);
      xfer(1'b1, 8'h00, 32'h4000_0001, 4'hF, 1'b0, rd);
      xfer(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, rd);
      chk("readback0", rd, 32'h4000_0001);

      xfer(1'b1, 8'h78, 32'h1122_3344, 4'hF, 1'b0, rd);
      xfer(1'b1, 8'h78, 32'hAABB_CCDD, 4'h5, 1'b0, rd);
      xfer(1'b0, 8'h78, 32'h0, 4'hF, 1'b0, rd);
      chk("strb_merge30", rd, 32'h11BB_33DD);

      xfer(1'b1, 8'hBC, 32'hDEAD_BEEF, 4'hF, 1'b0, rd);
      xfer(1'b0, 8'hBC, 32'h0, 4'hF, 1'b0, rd);

      xfer(1'b1, 8'hAC, 32'h0000_0005, 4'hF, 1'b0, rd);
      xfer(1'b0, 8'hAC, 32'h0, 4'hF, 1'b0, rd);
      chk("b2b_idx43", rd, 32'h5);

      xfer(1'b1, 8'h10, 32'h0000_1234, 4'hF, 1'b0, rd);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 8'h10; pwdata_i = 32'hCAFE_F00D; pstrb_i = 4'hF;
      @(negedge clk);
      penable_i = 1'b1;
      chk("mid_we_before", 32'(wrapper_we_o), 32'(1));
      #1 rstn_i = 1'b0;
      #1;
      chk("mid_we_drop", 32'(wrapper_we_o), 32'(0));
      chk("mid_pready", 32'(pready_o), 32'(0));
      chk("mid_state", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      psel_i = 1'b0; penable_i = 1'b0;
      rstn_i = 1'b1;
      @(negedge clk);
      chk_mem("mid_discard");
      xfer(1'b0, 8'h10, 32'h0, 4'hF, 1'b0, rd);
      chk("after_rst_rd", rd, 32'h0000_1234);

      for (int n = 0; n < 80; n++) begin
         wr = 1'($urandom);
         drop = ($urandom_range(0, 3) == 0);
         addr = {6'($urandom_range(0, 63)), 2'($urandom)};
         xfer(wr, addr, $urandom, 4'($urandom), drop, rd);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
